// File: rtl/mcdf_pkg.sv
// MCDF arbiter shared types and helpers.
// Channel count, FSM state type and packet-length decode.
package mcdf_pkg;

    localparam int CH_N = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_e;

    function automatic logic [5:0] pkglen_decode(input logic [2:0] code);
        logic [5:0] len;
        unique case (1'b1)
            (code == 3'd0): len = 6'd4;
            (code == 3'd1): len = 6'd8;
            (code == 3'd2): len = 6'd16;
            default:        len = 6'd32;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/mcdf_arbiter_if.sv
// MCDF arbiter channel and formatter bundle.
// slave = arbiter side, master = channel FIFOs plus formatter.
interface mcdf_arbiter_if #(
    parameter int DATA_W = 32
) ();
    logic              slv0_req_i;
    logic              slv1_req_i;
    logic              slv2_req_i;
    logic [DATA_W-1:0] slv0_data_i;
    logic [DATA_W-1:0] slv1_data_i;
    logic [DATA_W-1:0] slv2_data_i;
    logic              slv0_ack_o;
    logic              slv1_ack_o;
    logic              slv2_ack_o;
    logic              slv0_en_i;
    logic              slv1_en_i;
    logic              slv2_en_i;
    logic [1:0]        slv0_prio_i;
    logic [1:0]        slv1_prio_i;
    logic [1:0]        slv2_prio_i;
    logic [2:0]        slv0_pkglen_i;
    logic [2:0]        slv1_pkglen_i;
    logic [2:0]        slv2_pkglen_i;
    logic              fmt_ready_i;
    logic              pkg_val_o;
    logic [DATA_W-1:0] pkg_data_o;
    logic [1:0]        pkg_id_o;
    logic [5:0]        pkg_len_o;
    logic              pkg_first_o;
    logic              pkg_last_o;

    modport slave (
        input  slv0_req_i, slv1_req_i, slv2_req_i,
        input  slv0_data_i, slv1_data_i, slv2_data_i,
        input  slv0_en_i, slv1_en_i, slv2_en_i,
        input  slv0_prio_i, slv1_prio_i, slv2_prio_i,
        input  slv0_pkglen_i, slv1_pkglen_i, slv2_pkglen_i,
        input  fmt_ready_i,
        output slv0_ack_o, slv1_ack_o, slv2_ack_o,
        output pkg_val_o, pkg_data_o, pkg_id_o,
        output pkg_len_o, pkg_first_o, pkg_last_o
    );

    modport master (
        output slv0_req_i, slv1_req_i, slv2_req_i,
        output slv0_data_i, slv1_data_i, slv2_data_i,
        output slv0_en_i, slv1_en_i, slv2_en_i,
        output slv0_prio_i, slv1_prio_i, slv2_prio_i,
        output slv0_pkglen_i, slv1_pkglen_i, slv2_pkglen_i,
        output fmt_ready_i,
        input  slv0_ack_o, slv1_ack_o, slv2_ack_o,
        input  pkg_val_o, pkg_data_o, pkg_id_o,
        input  pkg_len_o, pkg_first_o, pkg_last_o
    );

endinterface

// File: rtl/mcdf_arb_pick.sv
// Combinational winner select: lowest prio value wins,
// ties go to the first eligible channel after last_id.
module mcdf_arb_pick
    import mcdf_pkg::*;
(
    input  logic [CH_N-1:0]       elig,
    input  logic [CH_N-1:0][1:0]  prio,
    input  logic [1:0]            last_id,
    output logic                  valid,
    output logic [1:0]            id
);

    logic [1:0]      best_p;
    logic [CH_N-1:0] cand;
    logic [1:0]      o0, o1, o2;

    // Best (numerically lowest) priority among eligible channels.
    always_comb begin
        best_p = 2'd3;
        for (int i = 0; i < CH_N; i++) begin
            if (elig[i] && (prio[i] < best_p)) best_p = prio[i];
        end
    end

    // Channels tied at the best priority.
    always_comb begin
        for (int i = 0; i < CH_N; i++) begin
            cand[i] = elig[i] & (prio[i] == best_p);
        end
    end

    // Cyclic search order starting right after last_id.
    always_comb begin
        o0 = 2'd0;
        o1 = 2'd1;
        o2 = 2'd2;
        unique case (1'b1)
            (last_id == 2'd0): begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
            (last_id == 2'd1): begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
            default: ;
        endcase
        id = 2'd0;
        if (cand[o2]) id = o2;
        if (cand[o1]) id = o1;
        if (cand[o0]) id = o0;
    end

    assign valid = |elig;

endmodule

// File: rtl/mcdf_arbiter.sv
// MCDF packet arbiter: grants one channel per packet and
// forwards its words through a single ready/valid output register.
module mcdf_arbiter
    import mcdf_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input logic           clk_i,
    input logic           rst_i,
    mcdf_arbiter_if.slave bus
);

    localparam logic [0:0] S_IDLE = 1'(IDLE);
    localparam logic [0:0] S_XFER = 1'(XFER);

    logic [0:0]           state;
    logic [1:0]           gnt_id;
    logic [1:0]           last_id;
    logic [5:0]           len_q;
    logic [4:0]           cnt;

    logic [CH_N-1:0]      req;
    logic [CH_N-1:0]      en;
    logic [CH_N-1:0]      elig;
    logic [CH_N-1:0]      ack;
    logic [CH_N-1:0][1:0] prio;
    logic [CH_N-1:0][2:0] code;

    logic                 pick_valid;
    logic [1:0]           pick_id;
    logic                 take;
    logic                 last_word;
    logic [DATA_W-1:0]    gnt_data;

    logic                 val_q;
    logic [DATA_W-1:0]    data_q;
    logic [1:0]           id_q;
    logic [5:0]           plen_q;
    logic                 first_q;
    logic                 last_q;

    assign req  = {bus.slv2_req_i, bus.slv1_req_i, bus.slv0_req_i};
    assign en   = {bus.slv2_en_i, bus.slv1_en_i, bus.slv0_en_i};
    assign prio = {bus.slv2_prio_i, bus.slv1_prio_i, bus.slv0_prio_i};
    assign code = {bus.slv2_pkglen_i, bus.slv1_pkglen_i,
                   bus.slv0_pkglen_i};
    assign elig = en & req;

    mcdf_arb_pick u_pick (
        .elig    (elig),
        .prio    (prio),
        .last_id (last_id),
        .valid   (pick_valid),
        .id      (pick_id)
    );

    // Head word of the granted channel.
    always_comb begin
        gnt_data = bus.slv0_data_i;
        unique case (1'b1)
            (gnt_id == 2'd1): gnt_data = bus.slv1_data_i;
            (gnt_id == 2'd2): gnt_data = bus.slv2_data_i;
            default: ;
        endcase
    end

    // Pop only while granted, data present and the output reg can take it.
    always_comb begin
        take = (state == S_XFER) & req[gnt_id]
             & (~val_q | bus.fmt_ready_i);
        ack  = {CH_N{take}} & (3'b001 << gnt_id);
    end

    assign last_word = ({1'b0, cnt} == (len_q - 6'd1));

    // Packet FSM: arbitrate in IDLE, count words in XFER.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            gnt_id  <= 2'd0;
            last_id <= 2'd2;
            len_q   <= 6'd0;
            cnt     <= 5'd0;
        end else if (state == S_IDLE) begin
            if (pick_valid) begin
                gnt_id <= pick_id;
                len_q  <= pkglen_decode(code[pick_id]);
                cnt    <= 5'd0;
                state  <= S_XFER;
            end
        end else if (take) begin
            if (last_word) begin
                cnt     <= 5'd0;
                last_id <= gnt_id;
                state   <= S_IDLE;
            end else begin
                cnt <= cnt + 5'd1;
            end
        end
    end

    // Output register: load on pop, drain on ready, hold while stalled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            val_q   <= 1'b0;
            data_q  <= '0;
            id_q    <= 2'd0;
            plen_q  <= 6'd0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (take) begin
            val_q   <= 1'b1;
            data_q  <= gnt_data;
            id_q    <= gnt_id;
            plen_q  <= len_q;
            first_q <= (cnt == 5'd0);
            last_q  <= last_word;
        end else if (bus.fmt_ready_i && val_q) begin
            val_q <= 1'b0;
        end
    end

    assign bus.slv0_ack_o  = ack[0];
    assign bus.slv1_ack_o  = ack[1];
    assign bus.slv2_ack_o  = ack[2];
    assign bus.pkg_val_o   = val_q;
    assign bus.pkg_data_o  = data_q;
    assign bus.pkg_id_o    = id_q;
    assign bus.pkg_len_o   = plen_q;
    assign bus.pkg_first_o = first_q;
    assign bus.pkg_last_o  = last_q;

endmodule

// File: tb/tb_mcdf_arbiter.sv
// Bench for mcdf_arbiter: FIFO models, directed scenarios,
// random traffic and a per-cycle behavioural reference.
module tb_mcdf_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mcdf_arbiter_if #(.DATA_W(32)) bus ();

    mcdf_arbiter #(.DATA_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] q2[$];
    logic [2:0]  gate = 3'b111;
    logic [2:0]  pop = 3'b000;
    logic [2:0]  en = 3'b000;
    logic [1:0]  prio[3] = '{2'd0, 2'd0, 2'd0};
    logic [2:0]  code[3] = '{3'd0, 3'd0, 3'd0};
    logic        ready = 1'b1;
    int          seq = 0;

    int ack_cnt[3] = '{0, 0, 0};
    int pk_ids[$];
    int pk_lens[$];
    int cur_words = 0;
    int n_acc = 0;

    // reference model state (state after the coming clock edge)
    bit          m_busy = 0;
    int          m_ch = 0;
    int          m_len = 0;
    int          m_cnt = 0;
    int          m_last = 2;
    logic        e_val = 0;
    logic [31:0] e_data = 0;
    logic [1:0]  e_id = 0;
    logic [5:0]  e_len = 0;
    logic        e_first = 0;
    logic        e_last = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] bus_req();
        return {bus.slv2_req_i, bus.slv1_req_i, bus.slv0_req_i};
    endfunction

    function automatic logic [2:0] bus_en();
        return {bus.slv2_en_i, bus.slv1_en_i, bus.slv0_en_i};
    endfunction

    function automatic logic [2:0] bus_ack();
        return {bus.slv2_ack_o, bus.slv1_ack_o, bus.slv0_ack_o};
    endfunction

    function automatic int bus_prio(int c);
        if (c == 0) return int'(bus.slv0_prio_i);
        if (c == 1) return int'(bus.slv1_prio_i);
        return int'(bus.slv2_prio_i);
    endfunction

    function automatic int bus_code(int c);
        if (c == 0) return int'(bus.slv0_pkglen_i);
        if (c == 1) return int'(bus.slv1_pkglen_i);
        return int'(bus.slv2_pkglen_i);
    endfunction

    function automatic logic [31:0] bus_data(int c);
        if (c == 0) return bus.slv0_data_i;
        if (c == 1) return bus.slv1_data_i;
        return bus.slv2_data_i;
    endfunction

    task automatic push(int c, int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] w;
            w = {c[1:0], 6'd0, seq[23:0]};
            seq++;
            if (c == 0) q0.push_back(w);
            else if (c == 1) q1.push_back(w);
            else q2.push_back(w);
        end
    endtask

    task automatic drive();
        bus.slv0_req_i    = gate[0] && (q0.size() > 0);
        bus.slv1_req_i    = gate[1] && (q1.size() > 0);
        bus.slv2_req_i    = gate[2] && (q2.size() > 0);
        bus.slv0_data_i   = (q0.size() > 0) ? q0[0] : 32'd0;
        bus.slv1_data_i   = (q1.size() > 0) ? q1[0] : 32'd0;
        bus.slv2_data_i   = (q2.size() > 0) ? q2[0] : 32'd0;
        bus.slv0_en_i     = en[0];
        bus.slv1_en_i     = en[1];
        bus.slv2_en_i     = en[2];
        bus.slv0_prio_i   = prio[0];
        bus.slv1_prio_i   = prio[1];
        bus.slv2_prio_i   = prio[2];
        bus.slv0_pkglen_i = code[0];
        bus.slv1_pkglen_i = code[1];
        bus.slv2_pkglen_i = code[2];
        bus.fmt_ready_i   = ready;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (pop[0] && q0.size() > 0) void'(q0.pop_front());
        if (pop[1] && q1.size() > 0) void'(q1.pop_front());
        if (pop[2] && q2.size() > 0) void'(q2.pop_front());
        pop = 3'b000;
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        q0.delete();
        q1.delete();
        q2.delete();
        gate = 3'b111;
        ready = 1'b1;
        for (int c = 0; c < 3; c++) ack_cnt[c] = 0;
        pk_ids.delete();
        pk_lens.delete();
        n_acc = 0;
        drive();
    endtask

    task automatic wait_pkts(int n, int budget);
        int b;
        b = budget;
        while (pk_lens.size() < n && b > 0) begin
            step();
            b--;
        end
        chk("pkts_done", 64'(pk_lens.size()), 64'(n));
    endtask

    task automatic wait_acks(int c, int n, int budget);
        int b;
        b = budget;
        while (ack_cnt[c] < n && b > 0) begin
            step();
            b--;
        end
        chk("acks_reached", 64'(ack_cnt[c] >= n), 64'd1);
    endtask

    // Per-cycle compare against the reference, then advance it.
    always @(negedge clk) begin
        logic [2:0] rq, ev, ea, da;
        int  best, bk, key;
        bit  was_busy;
        rq = bus_req();
        ev = bus_en();
        da = bus_ack();
        ea = 3'b000;
        if (m_busy && rq[m_ch] && (!e_val || bus.fmt_ready_i))
            ea[m_ch] = 1'b1;
        chk("ack", 64'(da), 64'(ea));
        chk("pkg_val", 64'(bus.pkg_val_o), 64'(e_val));
        if (e_val)
            chk("pkg_word",
                {22'd0, bus.pkg_id_o, bus.pkg_len_o, bus.pkg_first_o,
                 bus.pkg_last_o, bus.pkg_data_o},
                {22'd0, e_id, e_len, e_first, e_last, e_data});
        for (int c = 0; c < 3; c++) ack_cnt[c] += int'(da[c]);
        pop = da;
        if (bus.pkg_val_o && bus.fmt_ready_i) begin
            n_acc++;
            if (bus.pkg_first_o) begin
                pk_ids.push_back(int'(bus.pkg_id_o));
                cur_words = 1;
            end else begin
                cur_words++;
            end
            if (bus.pkg_last_o) pk_lens.push_back(cur_words);
        end
        if (rst) begin
            m_busy = 0; m_cnt = 0; m_last = 2;
            e_val = 0; e_data = 0; e_id = 0;
            e_len = 0; e_first = 0; e_last = 0;
        end else begin
            was_busy = m_busy;
            if (ea != 3'b000) begin
                e_val   = 1;
                e_data  = bus_data(m_ch);
                e_id    = 2'(m_ch);
                e_len   = 6'(m_len);
                e_first = (m_cnt == 0);
                m_cnt++;
                e_last  = (m_cnt == m_len);
                if (e_last) begin
                    m_busy = 0;
                    m_last = m_ch;
                    m_cnt  = 0;
                end
            end else if (bus.fmt_ready_i && e_val) begin
                e_val = 0;
            end
            if (!was_busy) begin
                best = -1;
                bk = 99;
                for (int c = 0; c < 3; c++) begin
                    if (ev[c] && rq[c]) begin
                        key = bus_prio(c) * 3 + (c - m_last + 5) % 3;
                        if (key < bk) begin
                            bk = key;
                            best = c;
                        end
                    end
                end
                if (best >= 0) begin
                    m_busy = 1;
                    m_ch   = best;
                    m_cnt  = 0;
                    m_len  = (bus_code(best) >= 3) ? 32
                                                   : (4 << bus_code(best));
                end
            end
        end
    end

    initial begin
        int exp2[5];
        int exp3[6];
        logic [31:0] held;
        logic [1:0]  heldid;
        int b;
        exp2 = '{1, 2, 1, 2, 0};
        exp3 = '{0, 1, 2, 0, 1, 2};
        drive();
        repeat (3) step();
        chk("rst_val", 64'(bus.pkg_val_o), 64'd0);
        chk("rst_data", 64'(bus.pkg_data_o), 64'd0);
        chk("rst_flags",
            64'({bus.pkg_id_o, bus.pkg_len_o, bus.pkg_first_o,
                 bus.pkg_last_o}), 64'd0);
        chk("rst_ack", 64'(bus_ack()), 64'd0);

        // single channel, 4-word packet
        do_reset();
        en = 3'b001;
        push(0, 4);
        drive();
        #1;
        chk("t1_idle_ack", 64'(bus.slv0_ack_o), 64'd0);
        step();
        chk("t1_first_ack", 64'(bus.slv0_ack_o), 64'd1);
        wait_pkts(1, 50);
        chk("t1_id", 64'(pk_ids[0]), 64'd0);
        chk("t1_len", 64'(pk_lens[0]), 64'd4);
        chk("t1_acks", 64'(ack_cnt[0]), 64'd4);

        // priority with round-robin among equal priority
        do_reset();
        en = 3'b111;
        prio = '{2'd2, 2'd1, 2'd1};
        push(0, 4);
        push(1, 8);
        push(2, 8);
        drive();
        wait_pkts(5, 200);
        for (int i = 0; i < 5; i++) chk("t2_order", 64'(pk_ids[i]), 64'(exp2[i]));

        // equal priority, 8-word packets, continuous request
        do_reset();
        en = 3'b111;
        prio = '{2'd0, 2'd0, 2'd0};
        code = '{3'd1, 3'd1, 3'd1};
        push(0, 16);
        push(1, 16);
        push(2, 16);
        drive();
        wait_pkts(6, 300);
        for (int i = 0; i < 6; i++) begin
            chk("t3_order", 64'(pk_ids[i]), 64'(exp3[i]));
            chk("t3_len", 64'(pk_lens[i]), 64'd8);
        end

        // formatter stall mid-packet
        do_reset();
        en = 3'b001;
        push(0, 8);
        drive();
        b = 60;
        while (n_acc < 3 && b > 0) begin step(); b--; end
        ready = 1'b0;
        drive();
        step();
        held = bus.pkg_data_o;
        heldid = bus.pkg_id_o;
        for (int i = 0; i < 3; i++) begin
            chk("t4_noack", 64'(bus_ack()), 64'd0);
            step();
        end
        chk("t4_hold_data", 64'(bus.pkg_data_o), 64'(held));
        chk("t4_hold_id", 64'(bus.pkg_id_o), 64'(heldid));
        ready = 1'b1;
        drive();
        wait_pkts(1, 60);
        chk("t4_len", 64'(pk_lens[0]), 64'd8);
        chk("t4_words", 64'(n_acc), 64'd8);

        // request bubbles on ch2 while ch0 becomes eligible
        do_reset();
        en = 3'b101;
        code = '{3'd0, 3'd0, 3'd0};
        push(2, 4);
        drive();
        wait_acks(2, 2, 40);
        gate = 3'b011;
        push(0, 4);
        drive();
        step();
        step();
        gate = 3'b111;
        drive();
        wait_pkts(2, 60);
        chk("t5_first", 64'(pk_ids[0]), 64'd2);
        chk("t5_second", 64'(pk_ids[1]), 64'd0);
        chk("t5_len", 64'(pk_lens[0]), 64'd4);

        // enable / length change mid-packet, then reset mid-packet
        do_reset();
        en = 3'b010;
        code = '{3'd0, 3'd1, 3'd0};
        push(1, 12);
        drive();
        wait_acks(1, 3, 40);
        en = 3'b000;
        code = '{3'd0, 3'd0, 3'd0};
        drive();
        wait_pkts(1, 60);
        chk("t6_len", 64'(pk_lens[0]), 64'd8);
        repeat (20) step();
        chk("t6_disabled", 64'(pk_ids.size()), 64'd1);
        en = 3'b010;
        drive();
        wait_acks(1, 10, 40);
        rst = 1'b1;
        step();
        chk("t6_rst_val", 64'(bus.pkg_val_o), 64'd0);
        chk("t6_rst_data", 64'(bus.pkg_data_o), 64'd0);
        chk("t6_rst_flags",
            64'({bus.pkg_id_o, bus.pkg_len_o, bus.pkg_first_o,
                 bus.pkg_last_o}), 64'd0);
        chk("t6_rst_ack", 64'(bus_ack()), 64'd0);
        rst = 1'b0;

        // random traffic against the reference
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 60 == 0) begin
                en = 3'($urandom_range(1, 7));
                for (int c = 0; c < 3; c++) begin
                    prio[c] = 2'($urandom_range(0, 3));
                    code[c] = 3'($urandom_range(0, 7));
                end
            end
            if ($urandom_range(0, 2) == 0) begin
                int c;
                c = $urandom_range(0, 2);
                if ((c == 0 && q0.size() < 40) ||
                    (c == 1 && q1.size() < 40) ||
                    (c == 2 && q2.size() < 40))
                    push(c, $urandom_range(1, 4));
            end
            ready = ($urandom_range(0, 3) != 0);
            gate = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7))
                                               : 3'b111;
            rst = ($urandom_range(0, 799) == 0);
            drive();
            step();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
